irq_ctrl: RTL and testbench

Machine-mode interrupt receiver in the core; consumes the CLINT's tmr_irq/sft_irq lines plus an asynchronous external interrupt.
- Maintains the mip view for CSR reads.
- Applies mie/mstatus.MIE enables and fixed RISC-V priority.
- Presents one interrupt at a time to the pipeline over a req/ack handshake; holds off new requests until mret.

---
 rtl/irq_ctrl_if.sv | 32 +++
 rtl/irq_ctrl.sv | 150 +++++++++++++++
 tb/tb_irq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Interrupt sources, enables and pipeline handshake between the core and irq_ctrl.
// The master side drives sources, enables, ack and mret. The slave side is irq_ctrl.
interface irq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            tmr_irq;
    logic            sft_irq;
    logic            ext_irq;
    logic            mstatus_mie;
    logic            mie_meie;
    logic            mie_msie;
    logic            mie_mtie;
    logic            irq_ack;
    logic            mret;
    logic            irq_req;
    logic [XLEN-1:0] irq_cause;
    logic [XLEN-1:0] mip_o;
    logic            irq_active;
    logic [31:0]     irq_count;

    modport master (
        output tmr_irq, sft_irq, ext_irq, mstatus_mie, mie_meie, mie_msie, mie_mtie,
        output irq_ack, mret,
        input  irq_req, irq_cause, mip_o, irq_active, irq_count
    );

    modport slave (
        input  tmr_irq, sft_irq, ext_irq, mstatus_mie, mie_meie, mie_msie, mie_mtie,
        input  irq_ack, mret,
        output irq_req, irq_cause, mip_o, irq_active, irq_count
    );
endinterface

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt receiver: samples timer/software/external lines, applies enables and
// fixed priority, and offers one request at a time to the pipeline. Define IRQ_COUNT_EN to add a taken-interrupt counter.
//
// state  | meaning
// IDLE   | no request outstanding, watching pending sources
// REQ    | irq_req high, cause frozen, waiting for irq_ack or withdrawal
// ACTIVE | trap taken, handler running until mret
module irq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int XLEN        = 32
) (
    input logic       clk,
    input logic       rst_n,
    irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] CAUSE_EXT = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
    localparam logic [XLEN-1:0] CAUSE_SFT = {1'b1, {(XLEN-5){1'b0}}, 4'h3};
    localparam logic [XLEN-1:0] CAUSE_TMR = {1'b1, {(XLEN-5){1'b0}}, 4'h7};

    logic                   r_mtip;
    logic                   r_msip;
    logic [SYNC_STAGES-1:0] r_ext_sync;
    state_t                 r_state;
    logic                   r_req;
    logic                   r_active;
    logic [XLEN-1:0]        r_cause;
    logic [2:0]             r_src;

    logic                   w_meip;
    logic [2:0]             w_pending;
    logic [2:0]             w_sel;
    logic [XLEN-1:0]        w_sel_cause;
    logic                   w_src_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtip     <= 1'b0;
            r_msip     <= 1'b0;
            r_ext_sync <= '0;
        end else begin
            r_mtip     <= bus.tmr_irq;
            r_msip     <= bus.sft_irq;
            r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], bus.ext_irq};
        end
    end

    assign w_meip = r_ext_sync[SYNC_STAGES-1];

    // Bit order {ext, sw, tmr} doubles as the priority order.
    assign w_pending = {w_meip & bus.mie_meie, r_msip & bus.mie_msie, r_mtip & bus.mie_mtie};

    always_comb begin
        w_sel       = 3'b000;
        w_sel_cause = '0;
        if (w_pending[2]) begin
            w_sel       = 3'b100;
            w_sel_cause = CAUSE_EXT;
        end else if (w_pending[1]) begin
            w_sel       = 3'b010;
            w_sel_cause = CAUSE_SFT;
        end else if (w_pending[0]) begin
            w_sel       = 3'b001;
            w_sel_cause = CAUSE_TMR;
        end
    end

    // Withdrawal only tracks the source that was latched, not any newer one.
    assign w_src_live = |(r_src & w_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_active <= 1'b0;
            r_cause  <= '0;
            r_src    <= 3'b000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.mstatus_mie && (|w_pending)) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_cause <= w_sel_cause;
                        r_src   <= w_sel;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        r_state  <= ACTIVE;
                        r_req    <= 1'b0;
                        r_active <= 1'b1;
                    end else if (!bus.mstatus_mie || !w_src_live) begin
                        r_state <= IDLE;
                        r_req   <= 1'b0;
                        r_cause <= '0;
                        r_src   <= 3'b000;
                    end
                end
                ACTIVE: begin
                    if (bus.mret) begin
                        r_state  <= IDLE;
                        r_active <= 1'b0;
                        r_cause  <= '0;
                        r_src    <= 3'b000;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_req    <= 1'b0;
                    r_active <= 1'b0;
                    r_cause  <= '0;
                    r_src    <= 3'b000;
                end
            endcase
        end
    end

    assign bus.irq_req    = r_req;
    assign bus.irq_active = r_active;
    assign bus.irq_cause  = r_cause;

    always_comb begin
        bus.mip_o     = '0;
        bus.mip_o[11] = w_meip;
        bus.mip_o[7]  = r_mtip;
        bus.mip_o[3]  = r_msip;
    end

`ifdef IRQ_COUNT_EN
    logic [31:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if ((r_state == REQ) && bus.irq_ack) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign bus.irq_count = r_count;
`else
    assign bus.irq_count = '0;
`endif
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed-vector bench for irq_ctrl: timer/ext latency, priority, freeze, withdrawal,
// masking, ignored ack/mret, async reset and the optional taken-interrupt counter.
module tb_irq_ctrl;
    localparam int XLEN = 32;
    localparam logic [31:0] C_EXT = 32'h8000_000B;
    localparam logic [31:0] C_SFT = 32'h8000_0003;
    localparam logic [31:0] C_TMR = 32'h8000_0007;
`ifdef IRQ_COUNT_EN
    localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
    localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    irq_ctrl_if #(.XLEN(XLEN)) bus ();

    irq_ctrl #(.SYNC_STAGES(2), .XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic req, input logic act, input logic [31:0] cause);
        check({tag, ".req"},    {31'd0, bus.irq_req},    {31'd0, req});
        check({tag, ".active"}, {31'd0, bus.irq_active}, {31'd0, act});
        check({tag, ".cause"},  bus.irq_cause,           cause);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.tmr_irq = 0; bus.sft_irq = 0; bus.ext_irq = 0;
        bus.mstatus_mie = 0; bus.mie_meie = 0; bus.mie_msie = 0; bus.mie_mtie = 0;
        bus.irq_ack = 0; bus.mret = 0;
        #2;
        check_out("reset", 0, 0, 32'h0);
        check("reset.mip", bus.mip_o, 32'h0);
        check("reset.count", bus.irq_count, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc();

        // Timer path
        bus.mstatus_mie = 1; bus.mie_mtie = 1; bus.tmr_irq = 1;
        cyc();
        check("tmr.mip", bus.mip_o, 32'h80);
        check_out("tmr.e1", 0, 0, 32'h0);
        cyc();
        check_out("tmr.e2", 1, 0, C_TMR);
        cyc();
        check_out("tmr.hold", 1, 0, C_TMR);
        bus.irq_ack = 1;
        cyc();
        bus.irq_ack = 0;
        check_out("tmr.ack", 0, 1, C_TMR);
        cyc(3);
        check_out("tmr.active_norq", 0, 1, C_TMR);
        bus.mret = 1;
        cyc();
        bus.mret = 0;
        check_out("tmr.mret", 0, 0, 32'h0);
        cyc();
        check_out("tmr.rereq", 1, 0, C_TMR);
        bus.irq_ack = 1;
        cyc();
        bus.irq_ack = 0; bus.tmr_irq = 0;
        cyc();
        bus.mret = 1;
        cyc();
        bus.mret = 0;
        cyc();
        check_out("tmr.clean", 0, 0, 32'h0);

        // External latency = SYNC_STAGES+1
        bus.mie_meie = 1; bus.ext_irq = 1;
        cyc();
        check_out("ext.e1", 0, 0, 32'h0);
        cyc();
        check("ext.mip", bus.mip_o, 32'h800);
        check_out("ext.e2", 0, 0, 32'h0);
        cyc();
        check_out("ext.e3", 1, 0, C_EXT);
        bus.irq_ack = 1;
        cyc();
        bus.irq_ack = 0; bus.ext_irq = 0;
        cyc(3);
        bus.mret = 1;
        cyc();
        bus.mret = 0;
        cyc();
        check_out("ext.clean", 0, 0, 32'h0);

        // Priority: all three pending when global enable opens
        bus.mstatus_mie = 0; bus.mie_msie = 1;
        bus.tmr_irq = 1; bus.sft_irq = 1; bus.ext_irq = 1;
        cyc(3);
        check("prio.mip", bus.mip_o, 32'h888);
        check_out("prio.masked", 0, 0, 32'h0);
        bus.mstatus_mie = 1;
        cyc();
        check_out("prio.ext", 1, 0, C_EXT);
        bus.irq_ack = 1;
        cyc();
        bus.irq_ack = 0;
        bus.tmr_irq = 0; bus.sft_irq = 0; bus.ext_irq = 0;
        cyc(3);
        bus.mret = 1;
        cyc();
        bus.mret = 0;
        cyc();

        // Freeze: sw arrives while timer request outstanding
        bus.tmr_irq = 1;
        cyc(2);
        check_out("frz.tmr", 1, 0, C_TMR);
        bus.sft_irq = 1;
        cyc(2);
        check("frz.mip", bus.mip_o, 32'h88);
        check_out("frz.hold", 1, 0, C_TMR);
        bus.irq_ack = 1;
        cyc();
        bus.irq_ack = 0;
        check_out("frz.ack", 0, 1, C_TMR);
        bus.tmr_irq = 0; bus.sft_irq = 0;
        cyc(2);
        bus.mret = 1;
        cyc();
        bus.mret = 0;
        cyc();

        // Withdrawal by global disable, then ack beating withdrawal
        bus.tmr_irq = 1;
        cyc(2);
        check_out("wd.req", 1, 0, C_TMR);
        bus.mstatus_mie = 0;
        cyc();
        check_out("wd.mie", 0, 0, 32'h0);
        bus.mstatus_mie = 1;
        cyc();
        check_out("wd.rereq", 1, 0, C_TMR);
        bus.mstatus_mie = 0; bus.irq_ack = 1;
        cyc();
        bus.irq_ack = 0; bus.mstatus_mie = 1;
        check_out("wd.ackwins", 0, 1, C_TMR);
        bus.tmr_irq = 0;
        cyc(2);
        bus.mret = 1;
        cyc();
        bus.mret = 0;
        cyc();

        // Withdrawal by the latched source dropping
        bus.tmr_irq = 1;
        cyc(2);
        check_out("wds.req", 1, 0, C_TMR);
        bus.tmr_irq = 0;
        cyc();
        check_out("wds.still", 1, 0, C_TMR);
        cyc();
        check_out("wds.gone", 0, 0, 32'h0);

        // ack / mret in IDLE are ignored
        bus.irq_ack = 1; bus.mret = 1;
        cyc();
        bus.irq_ack = 0; bus.mret = 0;
        check_out("ign.idle", 0, 0, 32'h0);

        // Masking by mie_msie
        bus.mie_msie = 0; bus.sft_irq = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_out("mask.off", 0, 0, 32'h0);
        end
        check("mask.mip", bus.mip_o, 32'h8);
        bus.mie_msie = 1;
        cyc();
        check_out("mask.on", 1, 0, C_SFT);
        bus.irq_ack = 1;
        cyc();
        bus.irq_ack = 0;
        check_out("mask.ack", 0, 1, C_SFT);

        // Async reset mid-cycle while ACTIVE
        #3;
        rst_n = 1'b0;
        #1;
        check_out("arst", 0, 0, 32'h0);
        check("arst.mip", bus.mip_o, 32'h0);
        check("arst.count", bus.irq_count, 32'h0);
        bus.sft_irq = 0;
        cyc();
        rst_n = 1'b1;
        cyc();
        check_out("arst.after", 0, 0, 32'h0);

        // Three taken interrupts
        for (int k = 0; k < 3; k++) begin
            bus.tmr_irq = 1;
            cyc(2);
            bus.irq_ack = 1;
            cyc();
            bus.irq_ack = 0; bus.tmr_irq = 0;
            cyc();
            bus.mret = 1;
            cyc();
            bus.mret = 0;
            cyc();
        end
        check("count.three", bus.irq_count, EXP_CNT3);
        check_out("count.idle", 0, 0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
